// File: rtl/md5_search_ctrl_if.sv
// Stage-0 feed and result taps of the unrolled MD5 round pipeline.
// The pipeline is free-running: no valid, no stall, fixed depth.
interface md5_search_ctrl_if;
   logic [31:0]  pipe_a;
   logic [31:0]  pipe_b;
   logic [31:0]  pipe_c;
   logic [31:0]  pipe_d;
   logic [511:0] pipe_m;
   logic [31:0]  res_a;
   logic [31:0]  res_b;
   logic [31:0]  res_c;
   logic [31:0]  res_d;

   modport master (
      output pipe_a, pipe_b, pipe_c, pipe_d, pipe_m,
      input  res_a, res_b, res_c, res_d
   );

   modport slave (
      input  pipe_a, pipe_b, pipe_c, pipe_d, pipe_m,
      output res_a, res_b, res_c, res_d
   );
endinterface

// File: rtl/md5_search_ctrl.sv
// Candidate sequencer for a free-running MD5 pipeline: issues one block per clock,
// tags results LATENCY+1 clocks later and reports the first digest match; no backpressure.
module md5_search_ctrl #(
   parameter int LATENCY = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [31:0]  range_lo,
   input  logic [31:0]  range_hi,
   input  logic [127:0] target_digest,
   md5_search_ctrl_if.master pipe,
   output logic         busy,
   output logic         found,
   output logic         done,
   output logic [31:0]  match_cand,
   output logic [31:0]  issued
);

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FOUND,
      S_EXH
   } state_t;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [511:0] msg(input logic [31:0] x);
      return {x, 8'h80, 408'b0, 8'h20, 56'b0};
   endfunction

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   cand;
   logic [31:0]   hi_q;
   logic [127:0]  target_q;
   logic [511:0]  m_q;
   logic          pipe_vld;
   logic [31:0]   pipe_cand;
   logic [LATENCY-1:0] tag_vld;
   logic [31:0]   tag_cand [LATENCY];
   logic [31:0]   match_q;
   logic [31:0]   issued_q;

   logic [127:0]  res_digest;
   logic          res_hit;
   logic          any_vld;
   logic          launch;
   logic          issue;
   logic          flush;
   logic          clear;
   logic          take_match;

   always_comb begin
      res_digest = {bswap(pipe.res_a + IV_A), bswap(pipe.res_b + IV_B),
                    bswap(pipe.res_c + IV_C), bswap(pipe.res_d + IV_D)};
      res_hit    = tag_vld[LATENCY-1] && (res_digest == target_q) &&
                   (state == S_RUN || state == S_DRAIN);
      // pipe_vld is the stage-0 tag and still counts as in flight
      any_vld    = pipe_vld || (|tag_vld);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      issue      = 1'b0;
      flush      = 1'b0;
      clear      = 1'b0;
      take_match = 1'b0;
      if (abort) begin
         state_nxt = S_IDLE;
         clear     = 1'b1;
      end else begin
         case (state)
            S_IDLE, S_FOUND, S_EXH: begin
               if (start) begin
                  launch    = 1'b1;
                  state_nxt = (range_hi < range_lo) ? S_EXH : S_RUN;
               end
            end
            S_RUN: begin
               if (res_hit) begin
                  take_match = 1'b1;
                  flush      = 1'b1;
                  state_nxt  = S_FOUND;
               end else begin
                  issue = 1'b1;
                  if (cand == hi_q) begin
                     state_nxt = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (res_hit) begin
                  take_match = 1'b1;
                  flush      = 1'b1;
                  state_nxt  = S_FOUND;
               end else if (!any_vld) begin
                  state_nxt = S_EXH;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cand      <= '0;
         hi_q      <= '0;
         target_q  <= '0;
         m_q       <= '0;
         pipe_vld  <= 1'b0;
         pipe_cand <= '0;
         tag_vld   <= '0;
         match_q   <= '0;
         issued_q  <= '0;
      end else begin
         if (launch) begin
            cand     <= range_lo;
            hi_q     <= range_hi;
            target_q <= target_digest;
            issued_q <= '0;
            match_q  <= '0;
         end
         pipe_vld <= issue;
         if (issue) begin
            m_q       <= msg(cand);
            pipe_cand <= cand;
            issued_q  <= issued_q + 32'd1;
            // saturate on the last candidate so range_hi = FFFFFFFF never wraps
            if (cand != hi_q) begin
               cand <= cand + 32'd1;
            end
         end
         if (take_match) begin
            match_q <= tag_cand[LATENCY-1];
         end
         tag_vld <= flush ? '0 : {tag_vld[LATENCY-2:0], pipe_vld};
      end
   end

   always_ff @(posedge clk) begin
      tag_cand[0] <= pipe_cand;
      for (int k = 1; k < LATENCY; k++) begin
         tag_cand[k] <= tag_cand[k-1];
      end
   end

   assign pipe.pipe_a = IV_A;
   assign pipe.pipe_b = IV_B;
   assign pipe.pipe_c = IV_C;
   assign pipe.pipe_d = IV_D;
   assign pipe.pipe_m = m_q;

   assign busy       = (state == S_RUN) || (state == S_DRAIN);
   assign found      = (state == S_FOUND);
   assign done       = (state == S_FOUND) || (state == S_EXH);
   assign match_cand = match_q;
   assign issued     = issued_q;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench: behavioural MD5 pipeline of fixed depth, searches against a brute-force range-scan model.
module tb_md5_search_ctrl;
   localparam int L = 64;
   localparam logic [31:0] A0 = 32'h67452301;
   localparam logic [31:0] B0 = 32'hefcdab89;
   localparam logic [31:0] C0 = 32'h98badcfe;
   localparam logic [31:0] D0 = 32'h10325476;
   localparam logic [127:0] ABCD = 128'he2fc714c4727ee9395f324cd2e7f331f;

   localparam logic [31:0] KT [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };
   localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [31:0]  range_lo;
   logic [31:0]  range_hi;
   logic [127:0] target_digest;
   logic         busy;
   logic         found;
   logic         done;
   logic [31:0]  match_cand;
   logic [31:0]  issued;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [127:0] stage [L];

   md5_search_ctrl_if pif ();

   md5_search_ctrl #(.LATENCY(L)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .range_lo(range_lo), .range_hi(range_hi), .target_digest(target_digest),
      .pipe(pif),
      .busy(busy), .found(found), .done(done),
      .match_cand(match_cand), .issued(issued)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [127:0] md5_compress(input logic [31:0] ia, ib, ic, id, input logic [511:0] m);
      logic [31:0] w [16];
      logic [31:0] a, b, c, d, f, t;
      int g;
      for (int i = 0; i < 16; i++) w[i] = bswap(m[511-32*i -: 32]);
      a = ia; b = ib; c = ic; d = id;
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0:       begin f = (b & c) | (~b & d); g = i;                end
            1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         endcase
         t = f + a + KT[i] + w[g];
         a = d; d = c; c = b;
         b = b + rotl(t, ST[(i / 16) * 4 + i % 4]);
      end
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] tb_msg(input logic [31:0] x);
      logic [511:0] m;
      m = '0;
      m[511:480] = x;
      m[479:472] = 8'h80;
      m[63:56]   = 8'h20;
      return m;
   endfunction

   function automatic logic [127:0] md5_digest(input logic [31:0] x);
      logic [127:0] s;
      logic [31:0] a, b, c, d;
      s = md5_compress(A0, B0, C0, D0, tb_msg(x));
      a = s[127:96] + A0; b = s[95:64] + B0; c = s[63:32] + C0; d = s[31:0] + D0;
      return {bswap(a), bswap(b), bswap(c), bswap(d)};
   endfunction

   // free-running pipeline: result of a block appears L clocks after it is sampled
   always @(posedge clk) begin
      stage[0] <= md5_compress(pif.pipe_a, pif.pipe_b, pif.pipe_c, pif.pipe_d, pif.pipe_m);
      for (int k = 1; k < L; k++) stage[k] <= stage[k-1];
   end
   assign pif.res_a = stage[L-1][127:96];
   assign pif.res_b = stage[L-1][95:64];
   assign pif.res_c = stage[L-1][63:32];
   assign pif.res_d = stage[L-1][31:0];

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_match"}, match_cand, 0);
      chk({tag, "_issued"}, issued, 0);
      chk({tag, "_pipe_m"}, pif.pipe_m, 0);
   endtask

   task automatic run_search(input logic [31:0] lo, input logic [31:0] hi, input logic [127:0] tgt);
      int t0, tdone, k, n, exp_iss, d;
      bit hit;
      hit = 0; k = 0;
      n = (hi < lo) ? 0 : int'(hi - lo) + 1;
      for (int i = 0; i < n; i++) begin
         if (!hit && md5_digest(lo + i) == tgt) begin hit = 1; k = i; end
      end
      @(negedge clk);
      start = 1; range_lo = lo; range_hi = hi; target_digest = tgt;
      @(negedge clk);
      start = 0;
      t0 = cyc;
      tdone = -1;
      for (int w = 0; w < 400 && tdone < 0; w++) begin
         if (done) tdone = cyc;
         else @(negedge clk);
      end
      if (tdone < 0) begin
         chk("done_timeout", 0, 1);
         return;
      end
      d = tdone - t0;
      chk("found", found, hit);
      chk("busy_end", busy, 0);
      if (hit) begin
         exp_iss = (k + L + 1 < n) ? k + L + 1 : n;
         chk("match_cand", match_cand, lo + k);
         chk("issued_at_found", issued, exp_iss);
         chk("found_latency", d, k + L + 2);
      end else begin
         chk("match_cand_none", match_cand, 0);
         chk("issued_total", issued, n);
         if (n == 0) chk("empty_range_latency", d, 0);
         else begin
            chk("drain_window", (d >= n + L + 1) && (d <= n + L + 3), 1);
            chk("last_msg", pif.pipe_m, tb_msg(hi));
         end
      end
   endtask

   task automatic rst_and_watch(input string tag, input int delay);
      bit bad;
      @(negedge clk);
      start = 1; range_lo = 32'h61626360; range_hi = 32'h6162636f; target_digest = ABCD;
      @(negedge clk);
      start = 0;
      repeat (delay) @(negedge clk);
      chk({tag, "_busy_before"}, busy, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check_idle(tag);
      bad = 0;
      repeat (90) begin
         @(negedge clk);
         if (found || done || busy) bad = 1;
      end
      chk({tag, "_quiet"}, bad, 0);
   endtask

   initial begin
      rst = 1; start = 0; abort = 0;
      range_lo = '0; range_hi = '0; target_digest = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      chk("iv_a", pif.pipe_a, A0);
      chk("iv_b", pif.pipe_b, B0);
      chk("iv_c", pif.pipe_c, C0);
      chk("iv_d", pif.pipe_d, D0);
      rst = 0;

      run_search(32'h61626360, 32'h6162636f, ABCD);
      chk("abcd_cand", match_cand, 32'h61626364);
      run_search(32'h00000000, 32'h0000000f, ABCD);
      run_search(32'h00000010, 32'h0000000f, ABCD);
      run_search(32'hfffffffc, 32'hffffffff, ~ABCD);

      // abort while "abcd" is in flight; the start in the abort cycle must be ignored
      @(negedge clk);
      start = 1; range_lo = 32'h61626360; range_hi = 32'h6162636f; target_digest = ABCD;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      abort = 1; start = 1; range_lo = 0; range_hi = 3;
      @(negedge clk);
      abort = 0; start = 0;
      check_idle("abort");
      run_search(32'h0, 32'h3, ABCD);

      rst_and_watch("rst_run", 3);
      rst_and_watch("rst_drain", 20);

      for (int it = 0; it < 10; it++) begin
         logic [31:0] lo, hi;
         logic [127:0] tgt;
         int len, mode;
         lo = $urandom_range(1, 32'hffff0000);
         len = $urandom_range(1, 24);
         hi = lo + len - 1;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       tgt = md5_digest(lo + $urandom_range(0, len - 1));
            1:       tgt = {$urandom, $urandom, $urandom, $urandom};
            2:       tgt = md5_digest(hi + 1);
            default: begin hi = lo - 1; tgt = md5_digest(lo); end
         endcase
         run_search(lo, hi, tgt);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
